lsu_bus_if: RTL and testbench
=============================

// Module: lsu_bus_if
// PURPOSE
//  Parametrised load/store unit between the pipeline M stage and a data bus with wait states.
//  Generates byte enables, lane-shifted write data and sign/zero-extended load data.
//  Supports the req/ready + rvalid handshake, optional split of boundary-crossing accesses, and a bus timeout.
//  Stalls the pipeline until the access retires.
// PARAMETERS
//  XLEN     32  data/address width; 32 or 64. NB = XLEN/8 byte lanes.
//  SPLIT    1   1: boundary-crossing misaligned access done as two bus beats; 0: misalign error
//  TIMEOUT  16  max cycles per bus beat waiting for mem_ready or mem_rvalid; 0 disables the timeout
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      synchronous reset, active-high
//  req_valid   in   1      M-stage load/store present
//  req_we      in   1      1 = store, 0 = load
//  req_funct3  in   3      RISC-V funct3 (size = funct3[1:0]; funct3[2] = unsigned load)
//  req_addr    in   XLEN   byte address
//  req_wdata   in   XLEN   store data, LSB-aligned
//  stall       out  1      hold pipeline (combinational)
//  done        out  1      one-cycle retire pulse
//  ld_data     out  XLEN   extended load result, valid when done=1
//  err         out  2      00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
//  mem_req     out  1      bus request
//  mem_ready   in   1      bus accepts request
//  mem_we      out  1      bus write
//  mem_addr    out  XLEN   word-aligned bus address
//  mem_be      out  NB     byte enables
//  mem_wdata   out  XLEN   lane-shifted write data
//  mem_rvalid  in   1      read data valid
//  mem_rdata   in   XLEN   read data
// BEHAVIOUR
//  Reset: state=IDLE, phase=0, timeout counter=0; every output 0.
//  rst mid-transaction abandons the access: mem_req=0 the next cycle, no done; later mem_rvalid ignored.
//  States:
//   IDLE: stall = req_valid. Request sampled into regs, then go to REQ. Exception: error -> DONE.
//   REQ:  mem_req=1; mem_addr/be/we/wdata held stable until mem_req&&mem_ready.
//         Accepted load -> RESP. Accepted store -> REQ phase 1 if split pending, else DONE.
//   RESP: wait mem_rvalid, capture mem_rdata.
//         Then REQ phase 1 if split pending, else DONE. mem_rvalid outside RESP ignored.
//   DONE: done=1, stall=0; req_valid ignored (still the retiring instruction); next state IDLE.
//  stall = (state==IDLE & req_valid) | state==REQ | state==RESP.
//  ld_data and err are registered; they hold until the next accept.
//  Latency, zero-wait bus: load done at T+3, store done at T+2 (T = IDLE accept cycle).
//  Lane math: off = addr[log2(NB)-1:0]; sz = 1<<funct3[1:0] bytes; base = addr with low bits cleared.
//   Single beat (off+sz <= NB):
//    mem_be = ((1<<sz)-1) << off
//    mem_wdata = wdata << 8*off
//    load raw = rdata >> 8*off
//   Split (off+sz > NB, SPLIT=1):
//    beat0: base, be lanes off..NB-1, wdata << 8*off
//    beat1: base+NB, be lanes 0..off+sz-NB-1, wdata >> 8*(NB-off)
//    load raw = (rdata0 >> 8*off) | (rdata1 << 8*(NB-off))
//   Split case with SPLIT=0: err=01, no bus activity; IDLE -> DONE.
//  Load extend: mask raw to sz bytes; funct3[2]=0 sign-extends, 1 zero-extends. Stores: ld_data=0.
//  Illegal -> err=11, no bus activity:
//   funct3 011 with XLEN=32; funct3 111; funct3[2]=1 with req_we; funct3 110 with XLEN=32.
//  Timeout: counter clears on each REQ entry and on each RESP entry; increments in REQ/RESP.
//   When it reaches TIMEOUT: err=10, go to DONE, mem_req drops.
//   Late mem_ready/mem_rvalid is ignored.
// TESTING
//  LW 0x1000_0004, ready=1, rvalid next cycle with 0xDEADBEEF:
//   -> mem_be=1111, mem_addr=0x1000_0004, done at T+3, ld_data=0xDEADBEEF, err=00.
//  LB 0x1000_0003 with rdata 0x80123456 -> mem_be=1000, ld_data=0xFFFFFF80. Same with LBU -> 0x00000080.
//  SH 0x1000_0002, wdata 0x0000ABCD -> mem_be=1100, mem_wdata=0xABCD0000, mem_we=1, done at T+2.
//  LW 0x1000_0003, SPLIT=1:
//   -> beat0 0x1000_0000 be=1000 with rdata 0x44000000; beat1 0x1000_0004 be=0111 with rdata 0x00332211
//   -> ld_data=0x33221144. With SPLIT=0: err=01, mem_req never asserted.
//  TIMEOUT=8, mem_ready held 0 -> mem_req drops after 8 REQ cycles; done=1 with err=10; stall then 0.
//  rst asserted during RESP -> next cycle IDLE, stall=0, mem_req=0; following mem_rvalid produces no done.

Source files
------------

// File: rtl/lsu_bus_if.sv
// lsu_bus_if - load/store unit bridging the pipeline M stage to a data bus
// with wait states.
//
// It builds byte enables and lane-shifted store data, and sign- or
// zero-extends load data. Accesses that cross a bus word can be split into
// two beats. Each beat has a bounded wait for the bus. The pipeline is held
// in stall until the access retires with a one-cycle done pulse.
//
// Parameters
//   XLEN     data/address width (32 or 64); NB = XLEN/8 byte lanes
//   SPLIT    1: word-crossing access becomes two beats, 0: misaligned error
//   TIMEOUT  max cycles per beat waiting on mem_ready/mem_rvalid, 0 = off
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/we/funct3/addr/wdata M-stage access request
//   stall                          hold pipeline (combinational)
//   done, ld_data, err             retire pulse, extended load data, status
//   mem_req/ready/we/addr/be/wdata bus request channel
//   mem_rvalid/rdata               bus read response channel
module lsu_bus_if #(
    parameter int XLEN    = 32,
    parameter int SPLIT   = 1,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              stall,
    output logic              done,
    output logic [XLEN-1:0]   ld_data,
    output logic [1:0]        err,
    output logic              mem_req,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_r, next_state_s;
    logic                phase_r;
    logic                split_r;
    logic [2:0]          f3_r;
    logic [OFFW-1:0]     off_r;
    logic [NB-1:0]       be_hi_r;
    logic [XLEN-1:0]     wdata_hi_r;
    logic [XLEN-1:0]     rdata0_r;
    logic [TW-1:0]       tmo_cnt_r;
    logic                mem_req_r, mem_we_r, done_r;
    logic [XLEN-1:0]     mem_addr_r, mem_wdata_r, ld_data_r;
    logic [NB-1:0]       mem_be_r;
    logic [1:0]          err_r;

    logic [OFFW-1:0]     off_s;
    logic [3:0]          sz_s;
    logic [4:0]          span_s;
    logic                cross_s;
    logic                illegal_s;
    logic [1:0]          req_err_s;
    logic [2*NB-1:0]     be_wide_s;
    logic [2*XLEN-1:0]   wdata_wide_s;
    logic [XLEN-1:0]     base_s;
    logic                accept_s, beat_adv_s, ld_fin_s, tmo_s, clr_cnt_s, tmo_hit_s;
    logic [2*XLEN-1:0]   raw_wide_s;
    logic [XLEN-1:0]     ld_ext_s;

    // Masks raw load data to the access size, then sign- or zero-extends it.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                    input logic [2:0] f3);
        int   nbits;
        logic sbit;
        nbits = 32'sd8 << f3[1:0];
        case (f3[1:0])
            2'd0:    sbit = raw[7];
            2'd1:    sbit = raw[15];
            2'd2:    sbit = raw[31];
            default: sbit = raw[XLEN-1];
        endcase
        sbit = sbit & ~f3[2];
        for (int i = 0; i < XLEN; i++) begin
            load_extend[i] = (i < nbits) ? raw[i] : sbit;
        end
    endfunction

    // Lane math for the incoming request: offset, size, word crossing, enables.
    always_comb begin
        off_s        = req_addr[OFFW-1:0];
        sz_s         = 4'd1 << req_funct3[1:0];
        span_s       = 5'(off_s) + 5'(sz_s);
        cross_s      = (span_s > 5'(NB));
        base_s       = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
        // The low half of each wide vector is beat 0, the high half beat 1.
        wdata_wide_s = {{XLEN{1'b0}}, req_wdata} << {off_s, 3'b000};
        for (int i = 0; i < 2 * NB; i++) begin
            be_wide_s[i] = (5'(i) >= 5'(off_s)) && (5'(i) < span_s);
        end
    end

    // Request legality and the error code recorded at accept.
    always_comb begin
        illegal_s = (req_funct3 == 3'b111) ||
                    (req_funct3[2] && req_we) ||
                    ((XLEN == 32) && (req_funct3 == 3'b011)) ||
                    ((XLEN == 32) && (req_funct3 == 3'b110));
        if (illegal_s) begin
            req_err_s = 2'b11;
        end else if (cross_s && (SPLIT == 0)) begin
            req_err_s = 2'b01;
        end else begin
            req_err_s = 2'b00;
        end
    end

    // Load result assembly: on the second beat, beat 0 data supplies the low lanes.
    always_comb begin
        if (phase_r) begin
            raw_wide_s = {mem_rdata, rdata0_r} >> {off_r, 3'b000};
        end else begin
            raw_wide_s = {{XLEN{1'b0}}, mem_rdata} >> {off_r, 3'b000};
        end
        ld_ext_s = load_extend(raw_wide_s[XLEN-1:0], f3_r);
    end

    // Per-beat wait bound reached this cycle.
    always_comb begin
        tmo_hit_s = (TIMEOUT != 0) && (tmo_cnt_r == TW'(TIMEOUT - 1));
    end

    // Next-state logic and the per-cycle event strobes.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        beat_adv_s   = 1'b0;
        ld_fin_s     = 1'b0;
        tmo_s        = 1'b0;
        clr_cnt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (req_err_s != 2'b00) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_REQ;
                        clr_cnt_s    = 1'b1;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    if (!mem_we_r) begin
                        next_state_s = ST_RESP;
                        clr_cnt_s    = 1'b1;
                    end else if (split_r && !phase_r) begin
                        next_state_s = ST_REQ;
                        beat_adv_s   = 1'b1;
                        clr_cnt_s    = 1'b1;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else if (tmo_hit_s) begin
                    next_state_s = ST_DONE;
                    tmo_s        = 1'b1;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_RESP: begin
                if (mem_rvalid) begin
                    if (split_r && !phase_r) begin
                        next_state_s = ST_REQ;
                        beat_adv_s   = 1'b1;
                        clr_cnt_s    = 1'b1;
                    end else begin
                        next_state_s = ST_DONE;
                        ld_fin_s     = 1'b1;
                    end
                end else if (tmo_hit_s) begin
                    next_state_s = ST_DONE;
                    tmo_s        = 1'b1;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Combinational pipeline hold.
    always_comb begin
        stall = ((state_r == ST_IDLE) && req_valid) ||
                (state_r == ST_REQ) || (state_r == ST_RESP);
    end

    // State, request capture, beat sequencing, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            phase_r     <= 1'b0;
            split_r     <= 1'b0;
            f3_r        <= 3'd0;
            off_r       <= '0;
            be_hi_r     <= '0;
            wdata_hi_r  <= '0;
            rdata0_r    <= '0;
            tmo_cnt_r   <= '0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            done_r      <= 1'b0;
            mem_addr_r  <= '0;
            mem_be_r    <= '0;
            mem_wdata_r <= '0;
            ld_data_r   <= '0;
            err_r       <= 2'b00;
        end else begin
            state_r   <= next_state_s;
            mem_req_r <= (next_state_s == ST_REQ);
            done_r    <= (next_state_s == ST_DONE);

            if (clr_cnt_s) begin
                tmo_cnt_r <= '0;
            end else if ((state_r == ST_REQ) || (state_r == ST_RESP)) begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end

            if (accept_s) begin
                f3_r      <= req_funct3;
                off_r     <= off_s;
                split_r   <= cross_s;
                phase_r   <= 1'b0;
                err_r     <= req_err_s;
                ld_data_r <= '0;
                mem_we_r  <= req_we;
                // Erroring requests never reach the bus, so the bus fields keep their old values.
                if (req_err_s == 2'b00) begin
                    mem_addr_r  <= base_s;
                    mem_be_r    <= be_wide_s[NB-1:0];
                    mem_wdata_r <= wdata_wide_s[XLEN-1:0];
                    be_hi_r     <= be_wide_s[2*NB-1:NB];
                    wdata_hi_r  <= wdata_wide_s[2*XLEN-1:XLEN];
                end
            end else if (beat_adv_s) begin
                phase_r     <= 1'b1;
                mem_addr_r  <= mem_addr_r + XLEN'(NB);
                mem_be_r    <= be_hi_r;
                mem_wdata_r <= wdata_hi_r;
            end

            if ((state_r == ST_RESP) && mem_rvalid && !phase_r) begin
                rdata0_r <= mem_rdata;
            end

            if (ld_fin_s) begin
                ld_data_r <= ld_ext_s;
            end

            if (tmo_s) begin
                err_r <= 2'b10;
            end
        end
    end

    assign done      = done_r;
    assign ld_data   = ld_data_r;
    assign err       = err_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_lsu_bus_if.sv
module tb_lsu_bus_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_valid0 = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        mem_ready = 1'b1, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        stall, done, mem_req, mem_we;
    logic [31:0] ld_data, mem_addr, mem_wdata;
    logic [1:0]  err;
    logic [3:0]  mem_be;
    logic        stall0, done0, mem_req0, mem_we0;
    logic [31:0] ld_data0, mem_addr0, mem_wdata0;
    logic [1:0]  err0;
    logic [3:0]  mem_be0;

    int checks = 0;
    int errors = 0;

    // Bus model controls (written by the tests) and log (written by the model)
    logic        rd_en = 1'b1, stray_rv = 1'b0;
    logic [31:0] rd_lo = 32'd0, rd_hi = 32'd0;
    logic [31:0] q_addr[$];
    logic [3:0]  q_be[$];
    logic [31:0] q_wdata[$];
    logic        q_we[$];
    int          req_cycles = 0;

    always #5 clk = ~clk;

    lsu_bus_if #(.XLEN(32), .SPLIT(1), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .ld_data(ld_data), .err(err),
        .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

    lsu_bus_if #(.XLEN(32), .SPLIT(0), .TIMEOUT(8)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall0), .done(done0), .ld_data(ld_data0), .err(err0),
        .mem_req(mem_req0), .mem_ready(mem_ready), .mem_we(mem_we0),
        .mem_addr(mem_addr0), .mem_be(mem_be0), .mem_wdata(mem_wdata0),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

    // Bus responder: logs accepted beats, answers reads one cycle after acceptance
    initial begin : bus_model
        logic        pend;
        logic [31:0] pdata;
        pend = 1'b0;
        pdata = 32'd0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_rvalid = (pend && rd_en) || stray_rv;
            mem_rdata  = pend ? pdata : 32'h5A5A_5A5A;
            pend = 1'b0;
            if (mem_req) req_cycles++;
            if (mem_req && mem_ready) begin
                q_addr.push_back(mem_addr);
                q_be.push_back(mem_be);
                q_wdata.push_back(mem_wdata);
                q_we.push_back(mem_we);
                if (!mem_we) begin
                    pend = 1'b1;
                    pdata = mem_addr[2] ? rd_hi : rd_lo;
                end
            end
        end
    end

    task automatic start(input logic sel, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wdata;
        if (sel) req_valid0 = 1'b1;
        else req_valid = 1'b1;
        #1;
        checks++;
        if ((sel ? stall0 : stall) !== 1'b1) begin
            errors++;
            $display("FAIL stall_on_request got %b exp 1", sel ? stall0 : stall);
        end
    endtask

    task automatic wait_done(input logic sel, input int maxc, output int cyc,
                             output logic req_seen);
        logic seen;
        seen = 1'b0;
        req_seen = 1'b0;
        cyc = 0;
        for (int i = 1; i <= maxc && !seen; i++) begin
            @(negedge clk);
            #1;
            if (sel ? mem_req0 : mem_req) req_seen = 1'b1;
            if (sel ? done0 : done) begin
                seen = 1'b1;
                cyc = i;
            end
        end
        req_valid = 1'b0;
        req_valid0 = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout got no done within %0d cycles", maxc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({stall, done, mem_req, mem_we, err} !== 6'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000", {stall, done, mem_req, mem_we, err});
        end
        checks++;
        if ({ld_data, mem_addr, mem_wdata, mem_be} !== 100'd0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h exp 0", ld_data, mem_addr, mem_wdata, mem_be);
        end
        rst = 1'b0;
    endtask

    task automatic test_load_word();
        int c; logic rs; int b0;
        b0 = q_addr.size();
        rd_hi = 32'hDEAD_BEEF;
        start(1'b0, 1'b0, 3'b010, 32'h1000_0004, 32'd0);
        wait_done(1'b0, 20, c, rs);
        checks++;
        if (c !== 3) begin errors++; $display("FAIL lw_latency got %0d exp 3", c); end
        checks++;
        if (ld_data !== 32'hDEAD_BEEF || err !== 2'b00) begin
            errors++; $display("FAIL lw_data got %h err %b exp deadbeef err 00", ld_data, err);
        end
        checks++;
        if (q_addr.size() !== b0 + 1 || q_addr[b0] !== 32'h1000_0004 || q_be[b0] !== 4'b1111) begin
            errors++; $display("FAIL lw_beat got n=%0d addr %h be %b exp 1 10000004 1111",
                               q_addr.size() - b0, q_addr[b0], q_be[b0]);
        end
    endtask

    task automatic test_load_byte();
        int c; logic rs; int b0;
        rd_lo = 32'h8012_3456;
        for (int k = 0; k < 2; k++) begin
            b0 = q_addr.size();
            start(1'b0, 1'b0, (k == 0) ? 3'b000 : 3'b100, 32'h1000_0003, 32'd0);
            wait_done(1'b0, 20, c, rs);
            checks++;
            if (q_be[b0] !== 4'b1000 || q_addr[b0] !== 32'h1000_0000) begin
                errors++; $display("FAIL lb_beat%0d got addr %h be %b exp 10000000 1000", k, q_addr[b0], q_be[b0]);
            end
            checks++;
            if (ld_data !== ((k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080)) begin
                errors++; $display("FAIL lb_ext%0d got %h exp %h", k, ld_data,
                                   (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            end
        end
    endtask

    task automatic test_store_half();
        int c; logic rs; int b0;
        b0 = q_addr.size();
        start(1'b0, 1'b1, 3'b001, 32'h1000_0002, 32'h0000_ABCD);
        wait_done(1'b0, 20, c, rs);
        checks++;
        if (c !== 2) begin errors++; $display("FAIL sh_latency got %0d exp 2", c); end
        checks++;
        if (q_be[b0] !== 4'b1100 || q_wdata[b0] !== 32'hABCD_0000 || q_we[b0] !== 1'b1) begin
            errors++; $display("FAIL sh_beat got be %b wdata %h we %b exp 1100 abcd0000 1",
                               q_be[b0], q_wdata[b0], q_we[b0]);
        end
        checks++;
        if (ld_data !== 32'd0 || err !== 2'b00) begin
            errors++; $display("FAIL sh_result got %h err %b exp 0 00", ld_data, err);
        end
    endtask

    task automatic test_split_load();
        int c; logic rs; int b0;
        b0 = q_addr.size();
        rd_lo = 32'h4400_0000;
        rd_hi = 32'h0033_2211;
        start(1'b0, 1'b0, 3'b010, 32'h1000_0003, 32'd0);
        wait_done(1'b0, 30, c, rs);
        checks++;
        if (q_addr.size() !== b0 + 2) begin
            errors++; $display("FAIL split_ld_beats got %0d exp 2", q_addr.size() - b0);
        end else begin
            checks++;
            if (q_addr[b0] !== 32'h1000_0000 || q_be[b0] !== 4'b1000) begin
                errors++; $display("FAIL split_ld_beat0 got %h %b exp 10000000 1000", q_addr[b0], q_be[b0]);
            end
            checks++;
            if (q_addr[b0+1] !== 32'h1000_0004 || q_be[b0+1] !== 4'b0111) begin
                errors++; $display("FAIL split_ld_beat1 got %h %b exp 10000004 0111", q_addr[b0+1], q_be[b0+1]);
            end
        end
        checks++;
        if (ld_data !== 32'h3322_1144 || c !== 5) begin
            errors++; $display("FAIL split_ld_data got %h at %0d exp 33221144 at 5", ld_data, c);
        end
    endtask

    task automatic test_split_store();
        int c; logic rs; int b0;
        b0 = q_addr.size();
        start(1'b0, 1'b1, 3'b010, 32'h1000_0001, 32'h1122_3344);
        wait_done(1'b0, 30, c, rs);
        checks++;
        if (q_addr.size() !== b0 + 2 || c !== 3) begin
            errors++; $display("FAIL split_st_beats got %0d beats at %0d exp 2 at 3", q_addr.size() - b0, c);
        end else begin
            checks++;
            if (q_be[b0] !== 4'b1110 || q_wdata[b0] !== 32'h2233_4400) begin
                errors++; $display("FAIL split_st_beat0 got %b %h exp 1110 22334400", q_be[b0], q_wdata[b0]);
            end
            checks++;
            if (q_addr[b0+1] !== 32'h1000_0004 || q_be[b0+1] !== 4'b0001 || q_wdata[b0+1] !== 32'h0000_0011) begin
                errors++; $display("FAIL split_st_beat1 got %h %b %h exp 10000004 0001 00000011",
                                   q_addr[b0+1], q_be[b0+1], q_wdata[b0+1]);
            end
        end
    endtask

    task automatic test_misalign_nosplit();
        int c; logic rs;
        start(1'b1, 1'b0, 3'b010, 32'h1000_0003, 32'd0);
        wait_done(1'b1, 20, c, rs);
        checks++;
        if (err0 !== 2'b01 || c !== 1) begin
            errors++; $display("FAIL misalign_err got %b at %0d exp 01 at 1", err0, c);
        end
        checks++;
        if (rs !== 1'b0) begin errors++; $display("FAIL misalign_noreq got mem_req %b exp 0", rs); end
    endtask

    task automatic test_illegal();
        int c; logic rs; int b0;
        for (int k = 0; k < 2; k++) begin
            b0 = q_addr.size();
            start(1'b0, (k == 1), (k == 0) ? 3'b011 : 3'b100, 32'h1000_0000, 32'h1234_5678);
            wait_done(1'b0, 20, c, rs);
            checks++;
            if (err !== 2'b11 || c !== 1) begin
                errors++; $display("FAIL illegal%0d_err got %b at %0d exp 11 at 1", k, err, c);
            end
            checks++;
            if (rs !== 1'b0 || q_addr.size() !== b0) begin
                errors++; $display("FAIL illegal%0d_nobus got req %b beats %0d exp 0 0", k, rs, q_addr.size() - b0);
            end
        end
    endtask

    task automatic test_timeout();
        int c; logic rs; int r0;
        mem_ready = 1'b0;
        r0 = req_cycles;
        start(1'b0, 1'b0, 3'b010, 32'h1000_0008, 32'd0);
        wait_done(1'b0, 30, c, rs);
        checks++;
        if (err !== 2'b10 || c !== 9) begin
            errors++; $display("FAIL timeout_err got %b at %0d exp 10 at 9", err, c);
        end
        checks++;
        if (req_cycles - r0 !== 8) begin
            errors++; $display("FAIL timeout_req_cycles got %0d exp 8", req_cycles - r0);
        end
        checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL timeout_release got stall %b req %b exp 0 0", stall, mem_req);
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_rst_in_resp();
        logic seen;
        rd_en = 1'b0;
        start(1'b0, 1'b0, 3'b010, 32'h1000_0004, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL rst_pre_resp got stall %b req %b exp 1 0", stall, mem_req);
        end
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_abandon got stall %b req %b done %b exp 0 0 0", stall, mem_req, done);
        end
        rst = 1'b0;
        stray_rv = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (i == 1) stray_rv = 1'b0;
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rst_stray_rvalid got done exp none"); end
        rd_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int c; logic rs;
        rd_hi = 32'hCAFE_F00D;
        start(1'b0, 1'b0, 3'b001, 32'h1000_0006, 32'd0);
        wait_done(1'b0, 20, c, rs);
        checks++;
        if (ld_data !== 32'hFFFF_CAFE || err !== 2'b00) begin
            errors++; $display("FAIL lh_after_rst got %h err %b exp ffffcafe 00", ld_data, err);
        end
        start(1'b0, 1'b0, 3'b101, 32'h1000_0006, 32'd0);
        wait_done(1'b0, 20, c, rs);
        checks++;
        if (ld_data !== 32'h0000_CAFE) begin
            errors++; $display("FAIL lhu_back_to_back got %h exp 0000cafe", ld_data);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_split_load();
        test_split_store();
        test_misalign_nosplit();
        test_illegal();
        test_timeout();
        test_rst_in_resp();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
